axi_rd_sched: RTL and testbench

Read-side block scheduler for the AXI burst read engine. Counts blocks the write path has finished (`i_wr_done` pulses) in a ring of `NUM_BLOCKS` fixed-size blocks. Issues one start pulse plus block address per block to the read engine and waits for its completion. It then advances the ring pointer and flags overflow and stalled bursts. It sits between the write-done source and the read engine and replaces the engine's free-running internal address stepping.

---
 rtl/axi_rd_pkg.sv | 22 ++
 rtl/blk_occ_cnt.sv | 39 +++
 rtl/axi_rd_sched.sv | 120 ++++++++++++
 tb/tb_axi_rd_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the block-ring read scheduler and the read engine.
package axi_rd_pkg;

   localparam int DEF_BLOCK_BYTES = 4096;
   localparam int DEF_NUM_BLOCKS  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } rd_state_e;

   // Ceiling log2; returns 0 for v <= 1.
   function automatic int clogb2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/blk_occ_cnt.sv
// Saturating up/down block occupancy counter; flags a dropped increment when full.
module blk_occ_cnt
   import axi_rd_pkg::*;
#(
   parameter int MAX_CNT = DEF_NUM_BLOCKS,
   parameter int CNT_W   = clogb2(MAX_CNT + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_level,
   output logic             o_ovf
);

   logic [CNT_W-1:0] r_level;
   logic             w_full;
   logic             w_empty;

   assign w_full  = (r_level == CNT_W'(MAX_CNT));
   assign w_empty = (r_level == '0);

   // Simultaneous inc and dec cancel, so a full ring never overflows on that cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level <= '0;
      end else begin
         case ({i_inc, i_dec})
            2'b10:   if (!w_full)  r_level <= r_level + CNT_W'(1);
            2'b01:   if (!w_empty) r_level <= r_level - CNT_W'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign o_level = r_level;
   assign o_ovf   = i_inc & ~i_dec & w_full;

endmodule

// File: rtl/axi_rd_sched.sv
// Read-side ring scheduler: issues one start+address per written block to the read engine.
module axi_rd_sched
   import axi_rd_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
   parameter int                    BLOCK_BYTES    = DEF_BLOCK_BYTES,
   parameter int                    NUM_BLOCKS     = DEF_NUM_BLOCKS,
   parameter int                    TIMEOUT_CYCLES = 4096
) (
   input  logic                               M_RD_aclk,
   input  logic                               M_RD_aresetn,
   input  logic                               i_enable,
   input  logic                               i_wr_done,
   input  logic                               i_rd_done,
   input  logic                               i_clr_err,
   output logic                               o_rd_start,
   output logic [ADDR_WIDTH-1:0]              o_rd_addr,
   output logic [clogb2(NUM_BLOCKS+1)-1:0]    o_level,
   output logic                               o_busy,
   output logic                               o_overflow,
   output logic                               o_timeout
);

   localparam int LVL_W  = clogb2(NUM_BLOCKS + 1);
   localparam int IDX_W  = clogb2(NUM_BLOCKS);
   localparam int WD_W   = clogb2(TIMEOUT_CYCLES);
   localparam int BLK_SH = clogb2(BLOCK_BYTES);

   rd_state_e             r_state;
   logic                  r_rd_start;
   logic                  r_busy;
   logic                  r_overflow;
   logic                  r_timeout;
   logic [ADDR_WIDTH-1:0] r_rd_addr;
   logic [IDX_W-1:0]      r_rd_idx;
   logic [WD_W-1:0]       r_wdog;

   logic [LVL_W-1:0]      w_level;
   logic                  w_ovf;
   logic                  w_dec;
   logic                  w_to_set;
   logic [ADDR_WIDTH-1:0] w_blk_addr;

   assign w_dec      = (r_state == DONE);
   assign w_blk_addr = BASE_ADDR + (ADDR_WIDTH'(r_rd_idx) << BLK_SH);
   // Fires on the edge that brings the watchdog to its limit, so the flag shows in that cycle.
   assign w_to_set   = (r_state == WAIT) && !i_rd_done &&
                       (r_wdog == WD_W'(TIMEOUT_CYCLES - 2));

   blk_occ_cnt #(
      .MAX_CNT (NUM_BLOCKS),
      .CNT_W   (LVL_W)
   ) u_occ (
      .i_clk   (M_RD_aclk),
      .i_rst_n (M_RD_aresetn),
      .i_inc   (i_wr_done),
      .i_dec   (w_dec),
      .o_level (w_level),
      .o_ovf   (w_ovf)
   );

   always_ff @(posedge M_RD_aclk or negedge M_RD_aresetn) begin
      if (!M_RD_aresetn) begin
         r_state    <= IDLE;
         r_rd_start <= 1'b0;
         r_busy     <= 1'b0;
         r_rd_addr  <= BASE_ADDR;
         r_rd_idx   <= '0;
         r_wdog     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_enable && (w_level != '0)) begin
                  r_state    <= START;
                  r_rd_start <= 1'b1;
                  r_busy     <= 1'b1;
                  r_rd_addr  <= w_blk_addr;
               end
            end
            START: begin
               r_state    <= WAIT;
               r_rd_start <= 1'b0;
               r_wdog     <= '0;
            end
            WAIT: begin
               if (i_rd_done)
                  r_state <= DONE;
               else if (r_wdog != WD_W'(TIMEOUT_CYCLES - 1))
                  r_wdog <= r_wdog + WD_W'(1);
            end
            DONE: begin
               r_state  <= IDLE;
               r_busy   <= 1'b0;
               r_rd_idx <= (r_rd_idx == IDX_W'(NUM_BLOCKS - 1)) ? '0 : r_rd_idx + IDX_W'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Sticky flags: a same-cycle set event beats the clear.
   always_ff @(posedge M_RD_aclk or negedge M_RD_aresetn) begin
      if (!M_RD_aresetn) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_overflow <= w_ovf    | (r_overflow & ~i_clr_err);
         r_timeout  <= w_to_set | (r_timeout  & ~i_clr_err);
      end
   end

   assign o_rd_start = r_rd_start;
   assign o_rd_addr  = r_rd_addr;
   assign o_level    = w_level;
   assign o_busy     = r_busy;
   assign o_overflow = r_overflow;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_axi_rd_sched.sv
// Self-checking bench for axi_rd_sched: vector table plus scoreboarded start addresses.
module tb_axi_rd_sched;
   import axi_rd_pkg::*;

   localparam int NB    = 16;
   localparam int BB    = 4096;
   localparam int LVL_W = clogb2(NB + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en, wr, rd, clr;
   logic             o_rd_start, o_busy, o_overflow, o_timeout;
   logic [31:0]      o_rd_addr;
   logic [LVL_W-1:0] o_level;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sb_e;
   int          m_idx  = 0;

   typedef struct {
      bit wr;
      bit clr;
      int lvl;
      bit ovf;
   } vec_t;
   vec_t tbl[21];

   axi_rd_sched #(
      .ADDR_WIDTH     (32),
      .BASE_ADDR      (32'h0),
      .BLOCK_BYTES    (BB),
      .NUM_BLOCKS     (NB),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .M_RD_aclk    (clk),
      .M_RD_aresetn (rst_n),
      .i_enable     (en),
      .i_wr_done    (wr),
      .i_rd_done    (rd),
      .i_clr_err    (clr),
      .o_rd_start   (o_rd_start),
      .o_rd_addr    (o_rd_addr),
      .o_level      (o_level),
      .o_busy       (o_busy),
      .o_overflow   (o_overflow),
      .o_timeout    (o_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_start();
      exp_q.push_back(32'(m_idx * BB));
      m_idx = (m_idx + 1) % NB;
   endtask

   task automatic do_reset();
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      m_idx = 0;
      en = 0; wr = 0; rd = 0; clr = 0;
      #2 rst_n = 0;
      tick(); tick();
      rst_n = 1;
      tick();
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      while (!o_rd_start && n < 20) begin
         tick();
         n++;
      end
      chk("start_seen", 64'(o_rd_start), 64'd1);
   endtask

   // Scoreboard: every start pulse must match the next expected ring address.
   always @(negedge clk) begin
      if (rst_n && o_rd_start) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected_start: got addr %0h want no start", o_rd_addr);
         end else begin
            sb_e = exp_q.pop_front();
            chk("sb_addr", 64'(o_rd_addr), 64'(sb_e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) tbl[i] = '{wr: 1'b1, clr: 1'b0, lvl: i + 1, ovf: 1'b0};
      tbl[16] = '{wr: 1'b1, clr: 1'b0, lvl: 16, ovf: 1'b1};
      tbl[17] = '{wr: 1'b0, clr: 1'b1, lvl: 16, ovf: 1'b0};
      tbl[18] = '{wr: 1'b1, clr: 1'b1, lvl: 16, ovf: 1'b1};
      tbl[19] = '{wr: 1'b0, clr: 1'b0, lvl: 16, ovf: 1'b1};
      tbl[20] = '{wr: 1'b0, clr: 1'b1, lvl: 16, ovf: 1'b0};

      en = 0; wr = 0; rd = 0; clr = 0; rst_n = 0;
      tick(); tick();
      chk("rst_start", 64'(o_rd_start), 64'd0);
      chk("rst_addr",  64'(o_rd_addr),  64'd0);
      chk("rst_level", 64'(o_level),    64'd0);
      chk("rst_busy",  64'(o_busy),     64'd0);
      chk("rst_ovf",   64'(o_overflow), 64'd0);
      chk("rst_to",    64'(o_timeout),  64'd0);
      rst_n = 1;
      tick();

      // Single block latency
      en = 1;
      repeat (3) tick();
      expect_start();
      wr = 1;
      tick(); wr = 0;
      chk("single_lvl_n1", 64'(o_level), 64'd1);
      chk("single_nostart_n1", 64'(o_rd_start), 64'd0);
      tick();
      chk("single_start_n2", 64'(o_rd_start), 64'd1);
      chk("single_addr_n2", 64'(o_rd_addr), 64'h0);
      chk("single_busy_n2", 64'(o_busy), 64'd1);
      repeat (10) tick();
      rd = 1;
      tick(); rd = 0;
      chk("single_busy_c1", 64'(o_busy), 64'd1);
      chk("single_lvl_c1", 64'(o_level), 64'd1);
      tick();
      chk("single_lvl_c2", 64'(o_level), 64'd0);
      chk("single_busy_c2", 64'(o_busy), 64'd0);

      // Ring wrap across 17 blocks
      do_reset();
      en = 1;
      for (int b = 0; b < 17; b++) begin
         expect_start();
         wr = 1;
         tick(); wr = 0;
         wait_start();
         repeat (5) tick();
         chk("wrap_addr_hold", 64'(o_rd_addr), 64'((b % NB) * BB));
         rd = 1;
         tick(); rd = 0;
         tick();
         chk("wrap_lvl", 64'(o_level), 64'd0);
         chk("wrap_busy", 64'(o_busy), 64'd0);
      end

      // Overflow and clear, table driven with enable low
      do_reset();
      for (int i = 0; i < 21; i++) begin
         wr  = tbl[i].wr;
         clr = tbl[i].clr;
         tick();
         wr = 0; clr = 0;
         chk("tbl_lvl",   64'(o_level),    64'(tbl[i].lvl));
         chk("tbl_ovf",   64'(o_overflow), 64'(tbl[i].ovf));
         chk("tbl_start", 64'(o_rd_start), 64'd0);
      end

      // Write-done in DONE at full ring; enable dropped during WAIT
      expect_start();
      en = 1;
      tick();
      chk("full_busy_start", 64'(o_busy), 64'd1);
      tick();
      en = 0;
      tick(); tick();
      rd = 1;
      tick(); rd = 0;
      wr = 1;
      tick(); wr = 0;
      chk("full_done_lvl", 64'(o_level), 64'd16);
      chk("full_done_ovf", 64'(o_overflow), 64'd0);
      chk("full_done_busy", 64'(o_busy), 64'd0);
      repeat (5) tick();
      chk("full_hold_lvl", 64'(o_level), 64'd16);
      chk("full_hold_busy", 64'(o_busy), 64'd0);

      // Write-done in DONE at level 3; enable dropped during START; stray rd_done
      do_reset();
      wr = 1;
      tick(); tick(); tick();
      wr = 0;
      chk("l3_lvl", 64'(o_level), 64'd3);
      expect_start();
      en = 1;
      tick();
      en = 0;
      tick();
      rd = 1;
      tick(); rd = 0;
      wr = 1;
      tick(); wr = 0;
      chk("l3_done_lvl", 64'(o_level), 64'd3);
      rd = 1;
      tick(); rd = 0;
      repeat (4) tick();
      chk("l3_hold_lvl", 64'(o_level), 64'd3);
      chk("l3_hold_busy", 64'(o_busy), 64'd0);

      // Watchdog with TIMEOUT_CYCLES = 8
      do_reset();
      en = 1;
      expect_start();
      wr = 1;
      tick(); wr = 0;
      wait_start();
      repeat (7) tick();
      chk("to_wait7", 64'(o_timeout), 64'd0);
      tick();
      chk("to_wait8", 64'(o_timeout), 64'd1);
      chk("to_busy8", 64'(o_busy), 64'd1);
      tick(); tick();
      chk("to_still_wait_busy", 64'(o_busy), 64'd1);
      chk("to_still_wait_start", 64'(o_rd_start), 64'd0);
      rd = 1;
      tick(); rd = 0;
      tick();
      chk("to_late_lvl", 64'(o_level), 64'd0);
      chk("to_late_busy", 64'(o_busy), 64'd0);
      chk("to_sticky", 64'(o_timeout), 64'd1);
      clr = 1;
      tick(); clr = 0;
      chk("to_clr", 64'(o_timeout), 64'd0);
      expect_start();
      wr = 1;
      tick(); wr = 0;
      wait_start();
      chk("to_next_addr", 64'(o_rd_addr), 64'h1000);
      tick();
      wr = 1;
      tick(); wr = 0;
      repeat (7) tick();
      chk("to_second", 64'(o_timeout), 64'd1);
      chk("pre_rst_lvl", 64'(o_level), 64'd2);

      // Asynchronous reset in WAIT
      #3 rst_n = 0;
      #1;
      chk("arst_start", 64'(o_rd_start), 64'd0);
      chk("arst_addr",  64'(o_rd_addr),  64'd0);
      chk("arst_level", 64'(o_level),    64'd0);
      chk("arst_busy",  64'(o_busy),     64'd0);
      chk("arst_ovf",   64'(o_overflow), 64'd0);
      chk("arst_to",    64'(o_timeout),  64'd0);
      tick();
      rst_n = 1;
      repeat (3) tick();
      chk("post_rst_busy", 64'(o_busy), 64'd0);
      chk("sb_final", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
